// File: rtl/layer_priority_mux.sv
// N-channel priority multiplexer for the VGA drawing pipeline: the lowest-index layer with an
// effective request wins the pixel, with per-layer enable and blink masking and per-frame overlap reporting.
module layer_priority_mux #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic [NUM_LAYERS-1:0]              layerEnable,
  input  logic [NUM_LAYERS-1:0]              blinkEnable,
  input  logic [NUM_LAYERS-1:0]              busRequest,
  input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] busRGB,
  input  logic [COLOR_W-1:0]                 backgroundRGB,
  output logic                               drawingRequest,
  output logic [COLOR_W-1:0]                 RGBout,
  output logic [$clog2(NUM_LAYERS)-1:0]      activeLayer,
  output logic                               collision
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] LAST_FRAME = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0]         frameCnt;
  logic                  blinkPhase;
  logic                  overlapFlag;
  logic [NUM_LAYERS-1:0] eff;
  logic                  winValid;
  logic [LW-1:0]         winIdx;
  logic [COLOR_W-1:0]    winRGB;
  logic                  overlapNow;
  logic                  seenOne;

  // Scanning from the lowest priority upwards lets the highest-priority hit overwrite the rest.
  always_comb begin
    eff        = busRequest & layerEnable & ({NUM_LAYERS{blinkPhase}} | ~blinkEnable);
    winValid   = 1'b0;
    winIdx     = '0;
    winRGB     = backgroundRGB;
    overlapNow = 1'b0;
    seenOne    = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        winValid = 1'b1;
        winIdx   = LW'(i);
        winRGB   = busRGB[i];
      end
    end
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (eff[i]) begin
        if (seenOne) overlapNow = 1'b1;
        seenOne = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBout         <= '0;
      activeLayer    <= '0;
      drawingRequest <= 1'b0;
    end else begin
      RGBout         <= winRGB;
      activeLayer    <= winIdx;
      drawingRequest <= winValid;
    end
  end

  // Blink phase changes only at frame boundaries so a layer never flickers mid-frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt   <= '0;
      blinkPhase <= 1'b1;
    end else if (startOfFrame) begin
      if (frameCnt == LAST_FRAME) begin
        frameCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        frameCnt <= frameCnt + CW'(1);
      end
    end
  end

  // An overlap seen in the startOfFrame cycle still belongs to the frame that is ending.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overlapFlag <= 1'b0;
      collision   <= 1'b0;
    end else if (startOfFrame) begin
      collision   <= overlapFlag | overlapNow;
      overlapFlag <= 1'b0;
    end else if (overlapNow) begin
      overlapFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed-vector bench for layer_priority_mux: priority, masking, blink, collision and reset scenarios.
module tb_layer_priority_mux;

  logic            clk;
  logic            resetN;
  logic            startOfFrame;
  logic [3:0]      layerEnable;
  logic [3:0]      blinkEnable;
  logic [3:0]      busRequest;
  logic [3:0][7:0] busRGB;
  logic [7:0]      backgroundRGB;
  logic            drawingRequest;
  logic [7:0]      RGBout;
  logic [1:0]      activeLayer;
  logic            collision;

  int vectors;
  int miscompares;

  layer_priority_mux #(.NUM_LAYERS(4), .COLOR_W(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .layerEnable(layerEnable), .blinkEnable(blinkEnable), .busRequest(busRequest),
    .busRGB(busRGB), .backgroundRGB(backgroundRGB), .drawingRequest(drawingRequest),
    .RGBout(RGBout), .activeLayer(activeLayer), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++; if (drawingRequest !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dr got=%0b exp=0", drawingRequest); end
    vectors++; if (RGBout !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rgb got=%h exp=00", RGBout); end
    vectors++; if (activeLayer !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_layer got=%0d exp=0", activeLayer); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_coll got=%0b exp=0", collision); end
  endtask

  task automatic test_priority();
    layerEnable = 4'b1111; blinkEnable = 4'b0000; busRequest = 4'b1010;
    busRGB[0] = 8'h11; busRGB[1] = 8'h1C; busRGB[2] = 8'h3A; busRGB[3] = 8'hE0;
    backgroundRGB = 8'h00;
    tick();
    vectors++; if (RGBout !== 8'h1C) begin miscompares++; $display("[TB] FAIL prio_rgb got=%h exp=1c", RGBout); end
    vectors++; if (activeLayer !== 2'd1) begin miscompares++; $display("[TB] FAIL prio_layer got=%0d exp=1", activeLayer); end
    vectors++; if (drawingRequest !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_dr got=%0b exp=1", drawingRequest); end
  endtask

  task automatic test_background();
    busRequest = 4'b0000; backgroundRGB = 8'hFF;
    tick();
    vectors++; if (RGBout !== 8'hFF) begin miscompares++; $display("[TB] FAIL bg_rgb got=%h exp=ff", RGBout); end
    vectors++; if (drawingRequest !== 1'b0) begin miscompares++; $display("[TB] FAIL bg_dr got=%0b exp=0", drawingRequest); end
    vectors++; if (activeLayer !== 2'd0) begin miscompares++; $display("[TB] FAIL bg_layer got=%0d exp=0", activeLayer); end
  endtask

  task automatic test_enable_mask();
    layerEnable = 4'b1101; busRequest = 4'b0110;
    tick();
    vectors++; if (RGBout !== 8'h3A) begin miscompares++; $display("[TB] FAIL mask_rgb got=%h exp=3a", RGBout); end
    vectors++; if (activeLayer !== 2'd2) begin miscompares++; $display("[TB] FAIL mask_layer got=%0d exp=2", activeLayer); end
    layerEnable = 4'b0000; busRequest = 4'b1111;
    tick();
    vectors++; if (drawingRequest !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_all_dr got=%0b exp=0", drawingRequest); end
    vectors++; if (RGBout !== 8'hFF) begin miscompares++; $display("[TB] FAIL mask_all_rgb got=%h exp=ff", RGBout); end
    layerEnable = 4'b1111;
  endtask

  // Inputs change every cycle; each output must reflect exactly the previous cycle's inputs.
  task automatic test_back_to_back();
    logic [3:0] reqs [6]   = '{4'b1000, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0000};
    logic [7:0] expRgb [6] = '{8'hE0, 8'hFF, 8'h11, 8'h3A, 8'h11, 8'hFF};
    logic [1:0] expLay [6] = '{2'd3, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic       expDr [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      busRequest = reqs[k];
      tick();
      vectors++; if (RGBout !== expRgb[k]) begin miscompares++; $display("[TB] FAIL b2b_rgb[%0d] got=%h exp=%h", k, RGBout, expRgb[k]); end
      vectors++; if (activeLayer !== expLay[k]) begin miscompares++; $display("[TB] FAIL b2b_layer[%0d] got=%0d exp=%0d", k, activeLayer, expLay[k]); end
      vectors++; if (drawingRequest !== expDr[k]) begin miscompares++; $display("[TB] FAIL b2b_dr[%0d] got=%0b exp=%0b", k, drawingRequest, expDr[k]); end
    end
  endtask

  task automatic test_collision();
    blinkEnable = 4'b0000; busRequest = 4'b0000;
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    busRequest = 4'b0100; tick(); tick();
    busRequest = 4'b0000; startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_clean got=%0b exp=0", collision); end
    busRequest = 4'b0011; tick();
    busRequest = 4'b0000; tick(); tick();
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_midframe got=%0b exp=0", collision); end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_set got=%0b exp=1", collision); end
    tick(); tick(); tick();
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_hold got=%0b exp=1", collision); end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_clear got=%0b exp=0", collision); end
    busRequest = 4'b0011; startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    busRequest = 4'b0000;
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_sofcycle got=%0b exp=1", collision); end
    tick(); tick();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_sof_owner got=%0b exp=0", collision); end
  endtask

  // Frame 0 is the span before the first startOfFrame; BLINK_FRAMES=2 gives visible 0-1, hidden 2-3, visible 4.
  task automatic test_blink();
    logic expVis [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic expDr;
    logic [7:0] expRgb;
    resetN = 1'b0; #3; resetN = 1'b1;
    blinkEnable = 4'b0001; busRequest = 4'b0001; backgroundRGB = 8'h22; busRGB[0] = 8'h55;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) begin
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        expDr = expVis[f-1];
        vectors++; if (drawingRequest !== expDr) begin miscompares++; $display("[TB] FAIL blink_sofcycle[%0d] got=%0b exp=%0b", f, drawingRequest, expDr); end
      end
      tick(); tick();
      expDr  = expVis[f];
      expRgb = expVis[f] ? 8'h55 : 8'h22;
      vectors++; if (drawingRequest !== expDr) begin miscompares++; $display("[TB] FAIL blink_dr[%0d] got=%0b exp=%0b", f, drawingRequest, expDr); end
      vectors++; if (RGBout !== expRgb) begin miscompares++; $display("[TB] FAIL blink_rgb[%0d] got=%h exp=%h", f, RGBout, expRgb); end
    end
  endtask

  // Continues from frame 4 of test_blink: two more frame starts enter the blink-off phase.
  task automatic test_reset_midframe();
    startOfFrame = 1'b1; tick(); tick(); startOfFrame = 1'b0;
    busRequest = 4'b0111; tick();
    vectors++; if (activeLayer !== 2'd1 || drawingRequest !== 1'b1 || RGBout !== 8'h1C) begin
      miscompares++; $display("[TB] FAIL rst_hidden_win got=%0d/%0b/%h exp=1/1/1c", activeLayer, drawingRequest, RGBout);
    end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_coll got=%0b exp=1", collision); end
    tick();
    #2; resetN = 1'b0; #1;
    vectors++; if (drawingRequest !== 1'b0 || RGBout !== 8'h00 || activeLayer !== 2'd0 || collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_async got=%0b/%h/%0d/%0b exp=0/00/0/0", drawingRequest, RGBout, activeLayer, collision);
    end
    #2; resetN = 1'b1;
    busRequest = 4'b0001; tick();
    vectors++; if (drawingRequest !== 1'b1 || RGBout !== 8'h55) begin
      miscompares++; $display("[TB] FAIL rst_phase got=%0b/%h exp=1/55", drawingRequest, RGBout);
    end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_first_sof got=%0b exp=0", collision); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    resetN = 1'b0; startOfFrame = 1'b0; layerEnable = '0; blinkEnable = '0;
    busRequest = '0; busRGB = '0; backgroundRGB = '0;
    #12;
    test_reset();
    resetN = 1'b1;
    test_priority();
    test_background();
    test_enable_mask();
    test_back_to_back();
    test_collision();
    test_blink();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_priority_mux.md
# layer_priority_mux

Parametrised N-channel priority multiplexer for the VGA drawing pipeline. It selects, each pixel clock, the RGB of the highest-priority object layer that requests drawing. It masks layers per-frame via enable and blink controls and reports inter-layer overlap once per frame. It sits between the object drawers (hearts, sprites, text) and the top-level objects mux, and replaces fixed 3-way sub-muxes.

## Interface
Parameters:
- NUM_LAYERS, 4: number of input channels, 2..16; index 0 is highest priority.
- COLOR_W, 8: RGB word width.
- BLINK_FRAMES, 30: frames per blink half-period, ≥1.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset; one clock; reset is asynchronous and active-low.
- startOfFrame  in  1  single-cycle pulse at frame start.
- layerEnable  in  NUM_LAYERS  per-layer static enable; 0 = layer ignored.
- blinkEnable  in  NUM_LAYERS  per-layer blink; 1 = layer hidden during blink-off phase.
- busRequest  in  NUM_LAYERS  per-layer drawing request.
- busRGB  in  NUM_LAYERS × COLOR_W  per-layer colour, packed [NUM_LAYERS-1:0][COLOR_W-1:0].
- backgroundRGB  in  COLOR_W  colour output when no layer wins.
- drawingRequest  out  1  registered; 1 when any effective request was present.
- RGBout  out  COLOR_W  registered selected colour.
- activeLayer  out  $clog2(NUM_LAYERS)  registered index of winning layer; 0 when none.
- collision  out  1  1 if ≥2 effective requests overlapped in any pixel of the previous frame.

## Operation
- Effective request: eff[i] = busRequest[i] & layerEnable[i] & (blinkPhase | ~blinkEnable[i]).
- Winner: the lowest index i with eff[i]=1. On the next edge, RGBout=busRGB[i], activeLayer=i, drawingRequest=1.
- No eff bit set: on the next edge, RGBout=backgroundRGB, activeLayer=0, drawingRequest=0.
- Blink state:
  - frameCnt, width $clog2(BLINK_FRAMES+1); blinkPhase, 1 bit, 1 = visible.
  - On startOfFrame: if frameCnt==BLINK_FRAMES-1, then frameCnt←0 and blinkPhase toggles. Otherwise frameCnt←frameCnt+1.
  - With BLINK_FRAMES=1, the phase toggles every frame.
- Overlap: overlapNow = (popcount(eff) ≥ 2). overlapFlag is sticky and set by overlapNow.
- Frame boundary: on startOfFrame, collision←overlapFlag|overlapNow, then overlapFlag←0. An overlap in the startOfFrame cycle belongs to the ending frame.
- collision holds its value for a full frame and updates only on startOfFrame.
- blinkPhase used for masking is the registered value. A phase toggle takes effect from the cycle after startOfFrame.

## Timing
- Mux path latency is exactly 1 clock, from inputs to RGBout/activeLayer/drawingRequest. All three are aligned.
- No combinational path from inputs to outputs.
- Reset values, applied asynchronously on resetN low:
  - RGBout=0, activeLayer=0, drawingRequest=0, collision=0.
  - frameCnt=0, blinkPhase=1, overlapFlag=0.
- Reset mid-frame discards the accumulated overlap. The first startOfFrame after reset reports collision for the partial frame only.
- startOfFrame held high for k cycles counts as k frames. Drivers must pulse it.
- Inputs change every clk. Throughput is one pixel per clock with no stalls.

## Test plan
- Priority: NUM_LAYERS=4, all enabled, busRequest=4'b1010, busRGB[1]=8'h1C, busRGB[3]=8'hE0 -> next cycle RGBout=8'h1C, activeLayer=1, drawingRequest=1.
- Background: busRequest=0, backgroundRGB=8'hFF -> next cycle RGBout=8'hFF, drawingRequest=0, activeLayer=0.
- Enable mask: layerEnable=4'b1101, busRequest=4'b0110 -> winner is layer 2, RGBout=busRGB[2].
- Blink: BLINK_FRAMES=2, blinkEnable[0]=1, busRequest=4'b0001 continuously.
  - Layer visible in frames 0–1, hidden in frames 2–3, visible again in frame 4.
  - While hidden: drawingRequest=0, RGBout=backgroundRGB.
- Collision: busRequest=4'b0011 for one pixel mid-frame -> collision=1 after the next startOfFrame. A following frame with no overlap -> collision=0 after the next startOfFrame.
- Reset: assert resetN=0 mid-frame after an overlap and during the blink-off phase -> all outputs 0 immediately and blinkPhase=1. The next startOfFrame yields collision=0.
